// File: rtl/vc_credit_allocator.sv
// vc_credit_allocator: downstream VC allocation and per-(port,VC) credit tracking beside the switch allocator
package params_noc;
    localparam int in_Port_Cnt = 5;
    typedef logic [2:0] inout_Port;
endpackage

module vc_credit_allocator
    import params_noc::*;
#(
    parameter int vc_Num    = 4,
    parameter int buf_Depth = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             va_req,
    input  inout_Port                                           dest_i [in_Port_Cnt][vc_Num],
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             flit_sent,
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             flit_tail,
    input  logic      [in_Port_Cnt-1:0][vc_Num-1:0]             credit_in,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0]             va_grant,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0][$clog2(vc_Num)-1:0] va_vc,
    output logic      [in_Port_Cnt-1:0][vc_Num-1:0]             sw_ok,
    output logic                                                credit_err
);
    localparam int N  = in_Port_Cnt * vc_Num;
    localparam int VW = $clog2(vc_Num);
    localparam int CW = $clog2(buf_Depth + 1);
    localparam int PW = $clog2(N);

    typedef enum logic {IDLE, BUSY} vc_state_t;

    vc_state_t state_q [in_Port_Cnt][vc_Num];
    vc_state_t state_d [in_Port_Cnt][vc_Num];
    logic [CW-1:0] credit_q [in_Port_Cnt][vc_Num];
    logic [CW-1:0] credit_d [in_Port_Cnt][vc_Num];
    logic [PW-1:0] ptr_q [in_Port_Cnt];
    logic [PW-1:0] ptr_d [in_Port_Cnt];
    logic [in_Port_Cnt-1:0][vc_Num-1:0] mapped_q, mapped_d, grant_q, grant_d;
    logic [in_Port_Cnt-1:0][vc_Num-1:0][VW-1:0] map_vc_q, map_vc_d;
    logic err_q, err_d;
    logic dec [in_Port_Cnt][vc_Num];

    // next state: sends/tail releases, one round-robin allocation per output, credit counters
    always_comb begin
        int idx, widx, fv;
        logic found, fok;
        idx = 0;
        widx = 0;
        fv = 0;
        found = 1'b0;
        fok = 1'b0;
        state_d = state_q;
        credit_d = credit_q;
        ptr_d = ptr_q;
        mapped_d = mapped_q;
        map_vc_d = map_vc_q;
        grant_d = '0;
        err_d = err_q;
        dec = '{default: '{default: 1'b0}};
        for (int i = 0; i < in_Port_Cnt; i++) begin
            for (int j = 0; j < vc_Num; j++) begin
                if (mapped_q[i][j] && flit_sent[i][j]) begin
                    dec[dest_i[i][j]][map_vc_q[i][j]] = 1'b1;
                    if (flit_tail[i][j]) begin
                        state_d[dest_i[i][j]][map_vc_q[i][j]] = IDLE;
                        mapped_d[i][j] = 1'b0;
                    end
                end
            end
        end
        for (int p = 0; p < in_Port_Cnt; p++) begin
            found = 1'b0;
            fok = 1'b0;
            widx = 0;
            fv = 0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr_q[p]) + k) % N;
                if (!found && va_req[idx/vc_Num][idx%vc_Num] && !mapped_q[idx/vc_Num][idx%vc_Num]
                    && dest_i[idx/vc_Num][idx%vc_Num] == inout_Port'(p)) begin
                    found = 1'b1;
                    widx = idx;
                end
            end
            for (int v = vc_Num - 1; v >= 0; v--) begin
                if (state_q[p][v] == IDLE) begin
                    fok = 1'b1;
                    fv = v;
                end
            end
            if (found && fok) begin
                state_d[p][fv] = BUSY;
                mapped_d[widx/vc_Num][widx%vc_Num] = 1'b1;
                map_vc_d[widx/vc_Num][widx%vc_Num] = VW'(fv);
                grant_d[widx/vc_Num][widx%vc_Num] = 1'b1;
                ptr_d[p] = (widx == N - 1) ? '0 : PW'(widx + 1);
            end
        end
        for (int p = 0; p < in_Port_Cnt; p++) begin
            for (int v = 0; v < vc_Num; v++) begin
                if (dec[p][v] && !credit_in[p][v]) begin
                    if (credit_q[p][v] == '0) err_d = 1'b1;
                    else credit_d[p][v] = credit_q[p][v] - 1'b1;
                end else if (credit_in[p][v] && !dec[p][v]) begin
                    if (credit_q[p][v] == CW'(buf_Depth)) err_d = 1'b1;
                    else credit_d[p][v] = credit_q[p][v] + 1'b1;
                end
            end
        end
    end

    // switch request qualifier: mapped and the held downstream VC has credit
    always_comb begin
        sw_ok = '0;
        for (int i = 0; i < in_Port_Cnt; i++)
            for (int j = 0; j < vc_Num; j++)
                sw_ok[i][j] = mapped_q[i][j] && (credit_q[dest_i[i][j]][map_vc_q[i][j]] != '0);
    end

    // state registers including the per-(port,VC) ownership FSMs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= '{default: '{default: IDLE}};
            credit_q <= '{default: '{default: CW'(buf_Depth)}};
            ptr_q    <= '{default: PW'(0)};
            mapped_q <= '0;
            map_vc_q <= '0;
            grant_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            ptr_q    <= ptr_d;
            mapped_q <= mapped_d;
            map_vc_q <= map_vc_d;
            grant_q  <= grant_d;
            err_q    <= err_d;
        end
    end

    assign va_grant   = grant_q;
    assign va_vc      = map_vc_q;
    assign credit_err = err_q;
endmodule
